// File: rtl/snowball_mem_pkg.sv
// Shared types and helpers for the snowball memory-port responder.
// SNOWBALL_MEMRSP_DMA_EN adds the DMA state to the encoding.
package snowball_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_RCOUNT  = 3'd2,
    ST_RBEAT0  = 3'd3,
    ST_RBEAT1  = 3'd4,
    ST_RELEASE = 3'd5
`ifdef SNOWBALL_MEMRSP_DMA_EN
    , ST_DMA   = 3'd6
`endif
  } state_t;

  localparam int RD_LAT_MIN = 2;
  localparam int RD_LAT_MAX = 7;

  localparam logic [31:0] PAIR_MASK = 32'h0000_0004;

  // Bursts wrap inside the aligned 8-byte pair, so the partner word never carries.
  function automatic logic [31:0] pair_partner(input logic [31:0] byte_addr);
    return byte_addr ^ PAIR_MASK;
  endfunction

endpackage

// File: rtl/snowball_mem_responder_if.sv
// Cache memory port, DMA arbitration and backing-RAM signals of the responder.
// slave = responder view, master = cache/RAM/DMA environment view.
interface snowball_mem_responder_if #(
  parameter int RAM_AW = 16
);
  logic [31:0]       mem_addr;
  logic              mem_we;
  logic              mem_do_act;
  logic [31:0]       mem_dataintomem;
  logic              mem_ack;
  logic [31:0]       mem_datafrommem;
  logic              dma_mcu_access;
  logic              dma_req;
  logic              dma_gnt;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  mem_addr, mem_we, mem_do_act, mem_dataintomem, dma_req, ram_rdata,
    output mem_ack, mem_datafrommem, dma_mcu_access, dma_gnt,
           ram_addr, ram_re, ram_we, ram_wdata
  );

  modport master (
    output mem_addr, mem_we, mem_do_act, mem_dataintomem, dma_req, ram_rdata,
    input  mem_ack, mem_datafrommem, dma_mcu_access, dma_gnt,
           ram_addr, ram_re, ram_we, ram_wdata
  );
endinterface

// File: rtl/snowball_mem_beatctr.sv
// Read beat counter: 3-bit count from the ack cycle, decoding the word0/word1
// RAM strobe positions on the next count so the strobes can be registered.
module snowball_mem_beatctr #(
  parameter int RD_LAT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_run,
  output logic o_last,
  output logic o_nxt_word0,
  output logic o_nxt_word1
);
  localparam logic [2:0] CNT_WORD0 = 3'(RD_LAT - 2);
  localparam logic [2:0] CNT_WORD1 = 3'(RD_LAT - 1);

  logic [2:0] r_cnt;
  logic [2:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_start)
      w_nxt = 3'd0;
    else if (i_run)
      w_nxt = r_cnt + 3'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= 3'd0;
    else
      r_cnt <= w_nxt;
  end

  assign o_last      = (r_cnt == CNT_WORD1);
  assign o_nxt_word0 = (w_nxt == CNT_WORD0);
  assign o_nxt_word1 = (w_nxt == CNT_WORD1);

endmodule

// File: rtl/snowball_mem_responder.sv
// MCU memory-port responder: single-word writes, critical-word-first 2-word reads,
// ack one cycle after the strobe, word0 RD_LAT cycles after ack; SNOWBALL_MEMRSP_DMA_EN adds DMA parking.
module snowball_mem_responder
  import snowball_mem_pkg::*;
#(
  parameter int RAM_AW = 16,
  parameter int RD_LAT = 4
) (
  input  logic                   MCU_CLK,
  input  logic                   RST,
  snowball_mem_responder_if.slave bus
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("snowball_mem_responder: RD_LAT out of range");
  end

  state_t            r_state;
  logic              r_mem_ack;
  logic [31:0]       r_mem_rdata;
  logic              r_ram_re;
  logic              r_ram_we;
  logic [RAM_AW-1:0] r_ram_addr;
  logic [31:0]       r_ram_wdata;
  logic [RAM_AW-1:0] r_req_waddr;

  logic              w_start_rd;
  logic              w_run;
  logic              w_last;
  logic              w_nxt_word0;
  logic              w_nxt_word1;
  logic [RAM_AW-1:0] w_req_waddr;
  logic [31:0]       w_pair_byte;
  logic [RAM_AW-1:0] w_pair_waddr;

  assign w_req_waddr  = bus.mem_addr[RAM_AW+1:2];
  assign w_pair_byte  = pair_partner(32'(r_req_waddr) << 2);
  assign w_pair_waddr = w_pair_byte[RAM_AW+1:2];
  assign w_start_rd   = (r_state == ST_IDLE) && bus.mem_do_act && !bus.mem_we;
  assign w_run        = (r_state == ST_RCOUNT);

  snowball_mem_beatctr #(.RD_LAT(RD_LAT)) u_beatctr (
    .i_clk       (MCU_CLK),
    .i_rst_n     (RST),
    .i_start     (w_start_rd),
    .i_run       (w_run),
    .o_last      (w_last),
    .o_nxt_word0 (w_nxt_word0),
    .o_nxt_word1 (w_nxt_word1)
  );

`ifdef SNOWBALL_MEMRSP_DMA_EN
  logic r_dma_gnt;
  logic r_dma_acc;
`endif

  // Every output is registered, so each branch sets what the next state must show.
  always_ff @(posedge MCU_CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_mem_ack   <= 1'b0;
      r_mem_rdata <= 32'd0;
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 32'd0;
      r_req_waddr <= '0;
`ifdef SNOWBALL_MEMRSP_DMA_EN
      r_dma_gnt   <= 1'b0;
      r_dma_acc   <= 1'b1;
`endif
    end else begin
      r_mem_ack <= 1'b0;
      r_ram_re  <= 1'b0;
      r_ram_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_do_act && bus.mem_we) begin
            r_state     <= ST_WRITE;
            r_mem_ack   <= 1'b1;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= w_req_waddr;
            r_ram_wdata <= bus.mem_dataintomem;
          end else if (bus.mem_do_act) begin
            r_state     <= ST_RCOUNT;
            r_mem_ack   <= 1'b1;
            r_req_waddr <= w_req_waddr;
            if (w_nxt_word0) begin
              r_ram_re   <= 1'b1;
              r_ram_addr <= w_req_waddr;
            end
`ifdef SNOWBALL_MEMRSP_DMA_EN
          end else if (bus.dma_req) begin
            r_state   <= ST_DMA;
            r_dma_gnt <= 1'b1;
            r_dma_acc <= 1'b0;
`endif
          end
        end
        ST_WRITE: r_state <= ST_RELEASE;
        ST_RCOUNT: begin
          if (w_nxt_word0) begin
            r_ram_re   <= 1'b1;
            r_ram_addr <= r_req_waddr;
          end else if (w_nxt_word1) begin
            r_ram_re   <= 1'b1;
            r_ram_addr <= w_pair_waddr;
          end
          if (w_last) begin
            r_mem_rdata <= bus.ram_rdata;
            r_state     <= ST_RBEAT0;
          end
        end
        ST_RBEAT0: begin
          r_mem_rdata <= bus.ram_rdata;
          r_state     <= ST_RBEAT1;
        end
        ST_RBEAT1: r_state <= ST_RELEASE;
        // The cache keeps its strobe up after ack; only a low strobe ends the transaction.
        ST_RELEASE: begin
          if (!bus.mem_do_act)
            r_state <= ST_IDLE;
        end
`ifdef SNOWBALL_MEMRSP_DMA_EN
        ST_DMA: begin
          if (!bus.dma_req) begin
            r_state   <= ST_IDLE;
            r_dma_gnt <= 1'b0;
            r_dma_acc <= 1'b1;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_ack         = r_mem_ack;
  assign bus.mem_datafrommem = r_mem_rdata;
  assign bus.ram_re          = r_ram_re;
  assign bus.ram_we          = r_ram_we;
  assign bus.ram_addr        = r_ram_addr;
  assign bus.ram_wdata       = r_ram_wdata;

`ifdef SNOWBALL_MEMRSP_DMA_EN
  assign bus.dma_gnt        = r_dma_gnt;
  assign bus.dma_mcu_access = r_dma_acc;
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, bus.mem_addr[31:RAM_AW+2], bus.mem_addr[1:0],
                         w_pair_byte[31:RAM_AW+2], w_pair_byte[1:0]};
`else
  assign bus.dma_gnt        = 1'b0;
  assign bus.dma_mcu_access = 1'b1;
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, bus.dma_req, bus.mem_addr[31:RAM_AW+2], bus.mem_addr[1:0],
                         w_pair_byte[31:RAM_AW+2], w_pair_byte[1:0]};
`endif

endmodule

// File: tb/tb_snowball_mem_responder.sv
// Randomized bench: per-cycle schedule model of acks, RAM strobes, read data and DMA grant.
module tb_snowball_mem_responder;
  localparam int RD_LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snowball_mem_responder_if #(.RAM_AW(16)) bus ();

  snowball_mem_responder #(.RAM_AW(16), .RD_LAT(RD_LAT)) dut (
    .MCU_CLK (clk),
    .RST     (rst_n),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Backing RAM seen by the DUT and an independent shadow used for expectations.
  logic [31:0] ram    [0:65535];
  logic [31:0] shadow [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ram[bus.ram_addr];
  end

  bit          ack_at   [int];
  bit          we_at    [int];
  bit          re_at    [int];
  logic [15:0] addr_at  [int];
  logic [31:0] wdata_at [int];
  logic [31:0] data_at  [int];
  bit          gnt_at   [int];
  logic [31:0] exp_data = 32'd0;
  bit          exp_gnt  = 1'b0;
  bit          chk_en   = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (data_at.exists(cyc)) exp_data = data_at[cyc];
      if (gnt_at.exists(cyc))  exp_gnt  = gnt_at[cyc];
      check("mem_ack", 32'(bus.mem_ack), 32'(ack_at.exists(cyc)));
      check("ram_we",  32'(bus.ram_we),  32'(we_at.exists(cyc)));
      check("ram_re",  32'(bus.ram_re),  32'(re_at.exists(cyc)));
      if (addr_at.exists(cyc)) check("ram_addr", 32'(bus.ram_addr), 32'(addr_at[cyc]));
      if (wdata_at.exists(cyc)) check("ram_wdata", bus.ram_wdata, wdata_at[cyc]);
      check("mem_datafrommem", bus.mem_datafrommem, exp_data);
      check("dma_gnt", 32'(bus.dma_gnt), 32'(exp_gnt));
      check("dma_mcu_access", 32'(bus.dma_mcu_access), 32'(!exp_gnt));
    end
  end

  // Request sampled at edge t0: ack in C0; write in C0; reads strobe word0/word1
  // at C(RD_LAT-2)/C(RD_LAT-1), data word0 in C(RD_LAT), word1 from C(RD_LAT+1).
  task automatic model_req(input int t0, input bit we, input logic [31:0] a, input logic [31:0] d);
    logic [15:0] w;
    w = a[17:2];
    ack_at[t0] = 1'b1;
    if (we) begin
      we_at[t0] = 1'b1;
      addr_at[t0] = w;
      wdata_at[t0] = d;
      shadow[w] = d;
    end else begin
      re_at[t0+RD_LAT-2] = 1'b1;
      addr_at[t0+RD_LAT-2] = w;
      re_at[t0+RD_LAT-1] = 1'b1;
      addr_at[t0+RD_LAT-1] = w ^ 16'd1;
      data_at[t0+RD_LAT] = shadow[w];
      data_at[t0+RD_LAT+1] = shadow[w ^ 16'd1];
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d, output int t0);
    bus.mem_do_act = 1'b1;
    bus.mem_we = we;
    bus.mem_addr = a;
    bus.mem_dataintomem = d;
    t0 = cyc + 1;
    model_req(t0, we, a, d);
  endtask

  // Strobe high for h sampling edges starting at t0.
  task automatic drop_act(input int t0, input int h);
    wait_until(t0 + h - 1);
    bus.mem_do_act = 1'b0;
    bus.mem_we = 1'($urandom);
    bus.mem_addr = $urandom;
  endtask

  // Leaves the driver on the negedge just before the first edge a new request is accepted.
  task automatic wait_free(input int t0, input int h, input bit we);
    int rel;
    rel = we ? 2 : RD_LAT + 3;
    if (h > rel) rel = h;
    wait_until(t0 + rel);
  endtask

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d, input int h);
    int t0;
    issue(we, a, d, t0);
    drop_act(t0, h);
    wait_free(t0, h, we);
  endtask

  task automatic dma_episode(input int len);
    int c;
    c = cyc;
    bus.dma_req = 1'b1;
`ifdef SNOWBALL_MEMRSP_DMA_EN
    gnt_at[c+1] = 1'b1;
`endif
    wait_until(c + len);
    bus.dma_req = 1'b0;
`ifdef SNOWBALL_MEMRSP_DMA_EN
    gnt_at[cyc+1] = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ack"},   32'(bus.mem_ack), 32'd0);
    check({tag, "_data"},  bus.mem_datafrommem, 32'd0);
    check({tag, "_gnt"},   32'(bus.dma_gnt), 32'd0);
    check({tag, "_acc"},   32'(bus.dma_mcu_access), 32'd1);
    check({tag, "_re"},    32'(bus.ram_re), 32'd0);
    check({tag, "_we"},    32'(bus.ram_we), 32'd0);
    check({tag, "_addr"},  32'(bus.ram_addr), 32'd0);
    check({tag, "_wdata"}, bus.ram_wdata, 32'd0);
  endtask

  initial begin
    int t0;
    logic [31:0] a;
    logic [31:0] v;
    int h;
    bus.mem_addr = 32'd0;
    bus.mem_we = 1'b0;
    bus.mem_do_act = 1'b0;
    bus.mem_dataintomem = 32'd0;
    bus.dma_req = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      v = 32'(i) * 32'h9E37_79B9 + 32'h0123_4567;
      ram[i] = v;
      shadow[i] = v;
    end

    repeat (3) @(negedge clk);
    reset_checks("por");
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Directed write held three cycles: single ack, RAM word 0x41.
    issue(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, t0);
    wait_until(t0);
    check("wr_ack_c0", 32'(bus.mem_ack), 32'd1);
    check("wr_we_c0", 32'(bus.ram_we), 32'd1);
    check("wr_addr_c0", 32'(bus.ram_addr), 32'h41);
    wait_until(t0 + 1);
    check("wr_noack_c1", 32'(bus.mem_ack), 32'd0);
    drop_act(t0, 3);
    wait_until(t0 + 2);
    check("wr_noack_c2", 32'(bus.mem_ack), 32'd0);
    wait_free(t0, 3, 1'b1);

    // Directed critical-word-first read of 0x104.
    do_req(1'b1, 32'h0000_0104, 32'h1111_1111, 2);
    do_req(1'b1, 32'h0000_0100, 32'h2222_2222, 1);
    issue(1'b0, 32'h0000_0104, 32'd0, t0);
    drop_act(t0, 3);
    wait_until(t0 + 4);
    check("rd_word0_c4", bus.mem_datafrommem, 32'h1111_1111);
    wait_until(t0 + 5);
    check("rd_word1_c5", bus.mem_datafrommem, 32'h2222_2222);
    wait_until(t0 + 9);
    check("rd_hold_c9", bus.mem_datafrommem, 32'h2222_2222);

    // Read and DMA request together: cache first, grant after release.
    bus.dma_req = 1'b1;
    issue(1'b0, 32'h0000_0200, 32'd0, t0);
`ifdef SNOWBALL_MEMRSP_DMA_EN
    gnt_at[t0+RD_LAT+4] = 1'b1;
    gnt_at[t0+RD_LAT+6] = 1'b0;
`endif
    drop_act(t0, 3);
    wait_until(t0 + RD_LAT + 3);
    check("sim_gnt_before", 32'(bus.dma_gnt), 32'd0);
    wait_until(t0 + RD_LAT + 4);
`ifdef SNOWBALL_MEMRSP_DMA_EN
    check("sim_gnt_after", 32'(bus.dma_gnt), 32'd1);
    check("sim_acc_after", 32'(bus.dma_mcu_access), 32'd0);
`else
    check("sim_gnt_after", 32'(bus.dma_gnt), 32'd0);
    check("sim_acc_after", 32'(bus.dma_mcu_access), 32'd1);
`endif
    wait_until(t0 + RD_LAT + 5);
    bus.dma_req = 1'b0;
    wait_until(t0 + RD_LAT + 6);
    check("sim_port_back", 32'(bus.dma_mcu_access), 32'd1);

    // Reset in C1 of a read.
    issue(1'b0, 32'h0000_0300, 32'd0, t0);
    wait_until(t0 + 1);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    bus.mem_do_act = 1'b0;
    #1 reset_checks("midrst");
    ack_at.delete(); we_at.delete(); re_at.delete(); addr_at.delete();
    wdata_at.delete(); data_at.delete(); gnt_at.delete();
    exp_data = 32'd0;
    exp_gnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_re", 32'(bus.ram_re), 32'd0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    issue(1'b1, 32'h0000_0308, 32'hCAFE_F00D, t0);
    wait_until(t0);
    check("post_rst_ack", 32'(bus.mem_ack), 32'd1);
    drop_act(t0, 2);
    wait_free(t0, 2, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 160; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[17:2] = 16'(256 + $urandom_range(0, 15));
      h = $urandom_range(1, 3);
      if (kind == 0)
        dma_episode($urandom_range(1, 4));
      else
        do_req(kind <= 4, a, $urandom, h);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
